ex_div: RTL and testbench

Iterative RV32M divider for the execute stage. Consumes operands and write-back address from the ID/EX pipeline register and computes DIV/DIVU/REM/REMU. It holds the front of the pipeline while it runs, then emits the result with a one-cycle write-enable toward the EX/MEM side. Radix-2 restoring algorithm: 32 iterations for normal operands, one cycle for the special cases.

---
 rtl/ex_div_if.sv | 26 ++
 rtl/ex_div.sv | 118 +++++++++++
 tb/tb_ex_div.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// ID/EX -> divider -> EX/MEM signal bundle.
// master: pipeline side driving operands; slave: the divider.
interface ex_div_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic        hold_req_o;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    input  hold_req_o, busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    output hold_req_o, busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
  );
endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU).
// 32 iterations for normal operands, single cycle for divide-by-zero and overflow.
module ex_div (
  input  logic      clk_100MHz,
  input  logic      arst_n,
  ex_div_if.slave   dif
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nx;
  logic [31:0] rem, dvd, dvs;
  logic [4:0]  cnt;
  logic        q_neg, r_neg, is_rem;
  logic [31:0] result;
  logic [4:0]  waddr;

  logic        start_ok, sgn, a_neg, b_neg, div0, ovf, special;
  logic [31:0] a_abs, b_abs, spec_res;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nx, dvd_nx, q_fin, r_fin, fin;

  assign start_ok = (state == IDLE) & dif.start_i & dif.op_i[2] & ~dif.flush_i;
  assign sgn      = ~dif.op_i[0];
  assign a_neg    = sgn & dif.dividend_i[31];
  assign b_neg    = sgn & dif.divisor_i[31];
  assign a_abs    = a_neg ? (~dif.dividend_i + 32'd1) : dif.dividend_i;
  assign b_abs    = b_neg ? (~dif.divisor_i + 32'd1) : dif.divisor_i;
  assign div0     = (dif.divisor_i == 32'd0);
  assign ovf      = sgn & (dif.dividend_i == 32'h8000_0000) & (dif.divisor_i == 32'hFFFF_FFFF);
  assign special  = div0 | ovf;

  always_comb begin
    spec_res = 32'd0;
    if (div0)
      spec_res = dif.op_i[1] ? dif.dividend_i : 32'hFFFF_FFFF;
    else if (ovf)
      spec_res = dif.op_i[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring step; 33 bits are enough since rem < divisor before the shift.
  assign rem_sh = {rem, dvd[31]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign rem_nx = diff[32] ? rem_sh[31:0] : diff[31:0];
  assign dvd_nx = {dvd[30:0], ~diff[32]};

  assign q_fin = q_neg ? (~dvd_nx + 32'd1) : dvd_nx;
  assign r_fin = r_neg ? (~rem_nx + 32'd1) : rem_nx;
  assign fin   = is_rem ? r_fin : q_fin;

  // State register
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (dif.flush_i)
      state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (start_ok) state_nx = special ? DONE : CALC;
        CALC:    if (cnt == 5'd31) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    dif.busy_o     = (state != IDLE);
    dif.hold_req_o = start_ok | (state == CALC);
    dif.ready_o    = (state == DONE) & ~dif.flush_i;
    dif.reg_we_o   = dif.ready_o;
  end

  assign dif.result_o    = result;
  assign dif.reg_waddr_o = waddr;

  // Datapath; flush freezes everything so the old result stays visible.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      rem    <= 32'd0;
      dvd    <= 32'd0;
      dvs    <= 32'd0;
      cnt    <= 5'd0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      is_rem <= 1'b0;
      result <= 32'd0;
      waddr  <= 5'd0;
    end else if (!dif.flush_i) begin
      if (start_ok) begin
        waddr <= dif.reg_waddr_i;
        if (special) begin
          result <= spec_res;
        end else begin
          dvd    <= a_abs;
          dvs    <= b_abs;
          rem    <= 32'd0;
          cnt    <= 5'd0;
          q_neg  <= a_neg ^ b_neg;
          r_neg  <= a_neg;
          is_rem <= dif.op_i[1];
        end
      end else if (state == CALC) begin
        rem <= rem_nx;
        dvd <= dvd_nx;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) result <= fin;
      end
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed-vector bench for ex_div: latency, hold window, special cases,
// flush mid-iteration and asynchronous reset mid-iteration.
module tb_ex_div;

  logic clk_100MHz = 1'b0;
  logic arst_n     = 1'b0;
  int   n_chk      = 0;
  int   n_fail     = 0;

  ex_div_if dif ();

  ex_div dut (
    .clk_100MHz (clk_100MHz),
    .arst_n     (arst_n),
    .dif        (dif.slave)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa,
                        input logic [31:0] exp_res, input int exp_cyc, input int exp_hold);
    int cyc;
    int hold_cnt;
    @(negedge clk_100MHz);
    dif.start_i     = 1'b1;
    dif.op_i        = op;
    dif.dividend_i  = a;
    dif.divisor_i   = b;
    dif.reg_waddr_i = wa;
    #1 hold_cnt = int'(dif.hold_req_o);
    @(posedge clk_100MHz);
    #1;
    dif.start_i     = 1'b0;
    dif.dividend_i  = 32'hDEAD_BEEF;
    dif.divisor_i   = 32'h0000_0003;
    dif.reg_waddr_i = 5'd0;
    #1 cyc = 1;
    while (!dif.ready_o && cyc < 100) begin
      hold_cnt += int'(dif.hold_req_o);
      @(posedge clk_100MHz);
      #2 cyc++;
    end
    hold_cnt += int'(dif.hold_req_o);
    chk({tag, " latency"}, cyc, exp_cyc);
    chk({tag, " result"}, dif.result_o, exp_res);
    chk({tag, " we"}, {31'd0, dif.reg_we_o}, 32'd1);
    chk({tag, " waddr"}, {27'd0, dif.reg_waddr_o}, {27'd0, wa});
    chk({tag, " hold cycles"}, hold_cnt, exp_hold);
    @(posedge clk_100MHz);
    #2;
    chk({tag, " ready pulse end"}, {31'd0, dif.ready_o}, 32'd0);
    chk({tag, " idle after"}, {31'd0, dif.busy_o}, 32'd0);
    chk({tag, " result stable"}, dif.result_o, exp_res);
  endtask

  initial begin
    int act;
    dif.start_i     = 1'b0;
    dif.op_i        = 3'b000;
    dif.dividend_i  = 32'd0;
    dif.divisor_i   = 32'd0;
    dif.reg_waddr_i = 5'd0;
    dif.flush_i     = 1'b0;
    #12;
    chk("rst result", dif.result_o, 32'd0);
    chk("rst outs", {27'd0, dif.busy_o, dif.hold_req_o, dif.ready_o, dif.reg_we_o, 1'b0}, 32'd0);
    @(negedge clk_100MHz);
    arst_n = 1'b1;

    run_op("divu 100/7",   DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33, 33);
    run_op("div -7/2",     DIV,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  33, 33);
    run_op("rem -7/2",     REM,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  33, 33);
    run_op("remu -7/2",    REMU, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'd1,          33, 33);
    run_op("div 5/0",      DIV,  32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  1,  1);
    run_op("remu 5/0",     REMU, 32'd5,          32'd0,          5'd10, 32'd5,          1,  1);
    run_op("div ovf",      DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  1,  1);
    run_op("rem ovf",      REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          1,  1);
    run_op("div min/1",    DIV,  32'h8000_0000,  32'd1,          5'd13, 32'h8000_0000,  33, 33);

    // Flush at iteration 10 of a DIVU 1000/3
    @(negedge clk_100MHz);
    dif.start_i = 1'b1; dif.op_i = DIVU; dif.dividend_i = 32'd1000;
    dif.divisor_i = 32'd3; dif.reg_waddr_i = 5'd20;
    @(posedge clk_100MHz);
    #1 dif.start_i = 1'b0;
    repeat (10) @(posedge clk_100MHz);
    #1 dif.flush_i = 1'b1;
    #1 chk("flush cycle ready", {31'd0, dif.ready_o}, 32'd0);
    @(posedge clk_100MHz);
    #1 dif.flush_i = 1'b0;
    #1;
    chk("flush busy", {31'd0, dif.busy_o}, 32'd0);
    chk("flush hold", {31'd0, dif.hold_req_o}, 32'd0);
    chk("flush result kept", dif.result_o, 32'h8000_0000);
    act = 0;
    repeat (40) begin
      @(posedge clk_100MHz);
      #2 act += int'(dif.ready_o | dif.busy_o);
    end
    chk("flush no activity", act, 0);
    run_op("divu 9/3",     DIVU, 32'd9,          32'd3,          5'd21, 32'd3,          33, 33);

    // Async reset at iteration 20
    @(negedge clk_100MHz);
    dif.start_i = 1'b1; dif.op_i = DIVU; dif.dividend_i = 32'd100;
    dif.divisor_i = 32'd7; dif.reg_waddr_i = 5'd5;
    @(posedge clk_100MHz);
    #1 dif.start_i = 1'b0;
    repeat (20) @(posedge clk_100MHz);
    #2 arst_n = 1'b0;
    #1;
    chk("arst result", dif.result_o, 32'd0);
    chk("arst waddr", {27'd0, dif.reg_waddr_o}, 32'd0);
    chk("arst outs", {28'd0, dif.busy_o, dif.hold_req_o, dif.ready_o, dif.reg_we_o}, 32'd0);
    @(negedge clk_100MHz);
    arst_n = 1'b1;
    dif.start_i = 1'b1; dif.op_i = 3'b000;
    act = 0;
    repeat (6) begin
      #1 act += int'(dif.hold_req_o | dif.busy_o | dif.ready_o);
      @(negedge clk_100MHz);
    end
    dif.start_i = 1'b0;
    chk("op000 ignored", act, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
